clk_enable_gen: RTL and testbench
=================================

Name: clk_enable_gen

Overview:
- Parametrised successor to the fixed-ratio PLL clocking block. It generates NUM_CH fractional-rate clock-enable pulse trains from sys_clk using phase accumulators, e.g. a PIT tick of about 1.193 MHz or a baud tick from 50 MHz.
- It also qualifies the PLL locked indication into a debounced ready/reset-release output.
- It sits beside the PLL wrapper. Downstream peripherals (PIT, UART, audio) run on sys_clk with these enables instead of extra PLL outputs.

Parameters:
- NUM_CH, 4, number of enable channels (1..8).
- ACC_WIDTH, 32, phase accumulator and increment width (8..32).
- INC_INIT, {NUM_CH{32'h0}}, packed NUM_CH*ACC_WIDTH reset increments; channel i occupies bits [i*ACC_WIDTH +: ACC_WIDTH].
- LOCK_STABLE, 1024, consecutive synchronised-locked cycles required before ready (>=2).
- CNT_W, 8, width of the lock-loss counter.

Ports:
- sys_clk  in  1  system clock, the only clock.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock; asynchronous to the logic, so it is synchronised internally.
- ch_en  in  NUM_CH  per-channel run enable.
- inc_wr  in  1  single-cycle increment write strobe.
- inc_sel  in  3  channel index for inc_wr.
- inc_data  in  ACC_WIDTH  new increment value.
- ce  out  NUM_CH  one-cycle enable pulses, registered.
- ready  out  1  high once lock has been stable; registered.
- lock_loss_cnt  out  CNT_W  saturating count of lock losses seen while in RUN.

Behaviour:
- Reset (async assert, applied at the next edge after release): ce=0, ready=0, lock_loss_cnt=0, accumulators=0, increments=INC_INIT, sync flops=0, FSM=WAIT_LOCK.
- pll_locked passes through a 2-flop synchroniser to give lk_s, so there are 2 cycles of latency.
- FSM states:
  - WAIT_LOCK: when lk_s=1, go to STABLE with stable counter=1.
  - STABLE: if lk_s=0, go to WAIT_LOCK and clear the counter. Otherwise increment; on reaching LOCK_STABLE, go to RUN.
  - RUN: if lk_s=0, go to WAIT_LOCK and increment lock_loss_cnt, saturating at all-ones.
- ready is registered (FSM==RUN). It rises on the cycle after the RUN transition and falls on the cycle after the cycle in which lk_s is sampled low while in RUN.
- Channel i when ready=1 and ch_en[i]=1: {carry, acc_i} <= acc_i + inc_i (ACC_WIDTH+1-bit add, wrapping); ce[i] <= carry.
  - Average ce rate = f_sys*inc_i/2^ACC_WIDTH.
  - First pulse appears on the cycle after the accumulate in which the carry occurs.
- Channel i when ready=1 and ch_en[i]=0: acc_i holds, ce[i]=0. Re-enabling resumes from the held phase.
- When ready=0: all acc cleared to 0 and all ce=0. After each lock, channels therefore restart phase-aligned.
- inc_i=0 gives no pulses. inc_i=2^ACC_WIDTH-1 gives a pulse on every cycle except one per 2^ACC_WIDTH.
- Increment writes:
  - inc_wr with inc_sel<NUM_CH updates inc[inc_sel] at the edge. The new value is used from the next accumulate; acc is not cleared.
  - inc_sel>=NUM_CH is ignored.
  - Writes are accepted in any FSM state.
- Write coinciding with an accumulate of the same channel: that accumulate uses the old increment.
- Lock dropping in STABLE does not increment lock_loss_cnt.
- Reset asserted mid-operation clears everything immediately, asynchronously.

Decomposition:
- Package clk_enable_pkg:
  - FSM state enum (WAIT_LOCK, STABLE, RUN).
  - Helper function computing inc = round(f_out*2^ACC_WIDTH/f_sys) for elaboration-time INC_INIT.
  - Constant for the PIT default (1193182 Hz at 50 MHz).
- Sub-module clk_en_accum:
  - One channel: acc register, adder, carry-to-ce flop, with en/clear/inc inputs.
  - Instantiated NUM_CH times in a generate loop.
- The top level holds the synchroniser, FSM, increment registers and loss counter.

Test Plan:
- Reset release, pll_locked=1 held, LOCK_STABLE=16 -> ready rises exactly 2 (sync) + 16 + 1 cycles after the first edge with pll_locked high; ce stays 0 throughout.
- ACC_WIDTH=8, inc0=64, ch_en=1 -> ce[0] pulses every 4th cycle; inc1=96 -> 3 pulses per 8 cycles, repeating pattern over 8 cycles; 0 pulses over 256 cycles with inc=0.
- Write inc0 128 -> 64 mid-run -> pulse spacing changes from 2 to 4 with no reset of phase; write with inc_sel=7 (NUM_CH=4) -> no increment changes.
- Drop pll_locked for 1 cycle in RUN -> ready falls 3 cycles later, ce all 0, lock_loss_cnt=1; relock -> LOCK_STABLE wait again; glitch during STABLE -> count unchanged.
- ch_en[2] low for 10 cycles mid-run -> no ce[2] pulses, acc held; re-enable -> pulse timing continues from the held phase.
- Async rst asserted between clock edges during RUN -> ce, ready, acc and cnt zero without waiting for an edge; increments return to INC_INIT.

Source files
------------

// File: rtl/clk_enable_pkg.sv
// ----------------------------------------------------------------------------
// clk_enable_pkg
// Shared types and elaboration-time helpers for the clock-enable generator.
//   lock_state_e : lock qualification FSM states
//   calc_inc()   : phase increment round(f_out * 2^acc_width / f_sys)
//   PitInc32     : increment for a 1.193182 MHz PIT tick from 50 MHz, 32-bit acc
// ----------------------------------------------------------------------------
package clk_enable_pkg;

   typedef enum logic [1:0] {
      StWaitLock,
      StStable,
      StRun
   } lock_state_e;

   localparam longint unsigned SysClkHz = 64'd50_000_000;
   localparam longint unsigned PitHz    = 64'd1_193_182;

   // Integer-only rounding: add f_sys/2 before the divide. f_out << 32 stays
   // below 2^64 for any output frequency under 4 GHz.
   function automatic logic [31:0] calc_inc(input longint unsigned f_out,
                                            input longint unsigned f_sys,
                                            input int unsigned     acc_width);
      longint unsigned num;
      num = (f_out << acc_width) + (f_sys >> 1);
      num = num / f_sys;
      return num[31:0];
   endfunction

   localparam logic [31:0] PitInc32 = calc_inc(PitHz, SysClkHz, 32);

endpackage

// File: rtl/clk_enable_gen_if.sv
// ----------------------------------------------------------------------------
// clk_enable_gen_if
// Control/status bundle of the clock-enable generator.
//   pll_locked    : raw PLL lock (asynchronous to sys_clk)
//   ch_en         : per-channel run enable
//   inc_wr/sel/data : increment write port (one-cycle strobe)
//   ce            : one-cycle enable pulses
//   ready         : lock qualified, channels running
//   lock_loss_cnt : saturating count of lock losses while running
// master drives the controls, slave is the generator.
// ----------------------------------------------------------------------------
interface clk_enable_gen_if #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned ACC_WIDTH = 32,
   parameter int unsigned CNT_W     = 8
);
   logic                 pll_locked;
   logic [NUM_CH-1:0]    ch_en;
   logic                 inc_wr;
   logic [2:0]           inc_sel;
   logic [ACC_WIDTH-1:0] inc_data;
   logic [NUM_CH-1:0]    ce;
   logic                 ready;
   logic [CNT_W-1:0]     lock_loss_cnt;

   modport master (
      output pll_locked, ch_en, inc_wr, inc_sel, inc_data,
      input  ce, ready, lock_loss_cnt
   );

   modport slave (
      input  pll_locked, ch_en, inc_wr, inc_sel, inc_data,
      output ce, ready, lock_loss_cnt
   );
endinterface

// File: rtl/clk_en_accum.sv
// ----------------------------------------------------------------------------
// clk_en_accum
// One fractional-rate enable channel: phase accumulator plus carry-out flop.
//   sys_clk, rst : clock, asynchronous active-high reset
//   en_i         : accumulate this cycle
//   clear_i      : zero the phase (takes priority over en_i)
//   inc_i        : phase increment
//   ce_o         : registered carry, one cycle per accumulator wrap
// ----------------------------------------------------------------------------
module clk_en_accum #(
   parameter int unsigned ACC_WIDTH = 32
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic                 en_i,
   input  logic                 clear_i,
   input  logic [ACC_WIDTH-1:0] inc_i,
   output logic                 ce_o
);

   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                 ce_q, ce_d;
   logic [ACC_WIDTH:0]   sum;

   always_comb begin
      sum   = {1'b0, acc_q} + {1'b0, inc_i};
      acc_d = acc_q;
      ce_d  = 1'b0;
      if (clear_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = sum[ACC_WIDTH-1:0];
         ce_d  = sum[ACC_WIDTH];
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         ce_q  <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ce_q  <= ce_d;
      end
   end

   assign ce_o = ce_q;

endmodule

// File: rtl/clk_enable_gen.sv
// ----------------------------------------------------------------------------
// clk_enable_gen
// Generates NUM_CH fractional-rate clock-enable pulse trains from sys_clk and
// qualifies PLL lock into a registered ready.
//   sys_clk : the only clock
//   rst     : asynchronous active-high reset
//   bus     : clk_enable_gen_if slave (controls in, ce/ready/lock_loss_cnt out)
// Channel i averages f_sys * inc_i / 2^ACC_WIDTH pulses per second while ready.
// ----------------------------------------------------------------------------
module clk_enable_gen
   import clk_enable_pkg::*;
#(
   parameter int unsigned                  NUM_CH      = 4,
   parameter int unsigned                  ACC_WIDTH   = 32,
   parameter logic [NUM_CH*ACC_WIDTH-1:0]  INC_INIT    = '0,
   parameter int unsigned                  LOCK_STABLE = 1024,
   parameter int unsigned                  CNT_W       = 8
) (
   input logic             sys_clk,
   input logic             rst,
   clk_enable_gen_if.slave bus
);

   localparam int unsigned StabW = $clog2(LOCK_STABLE + 1);

   logic [1:0]           sync_q;
   logic                 lk_s;
   lock_state_e          state_q;
   logic [StabW-1:0]     stable_cnt_q;
   logic                 ready_q;
   logic [CNT_W-1:0]     loss_cnt_q;
   logic [ACC_WIDTH-1:0] inc_q [NUM_CH];
   logic [ACC_WIDTH-1:0] inc_d [NUM_CH];
   logic [NUM_CH-1:0]    ce_w;

   // Two-flop synchroniser for the asynchronous lock indication.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], bus.pll_locked};
      end
   end

   assign lk_s = sync_q[1];

   // Lock qualification FSM with registered ready and loss counter.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q      <= StWaitLock;
         stable_cnt_q <= '0;
         ready_q      <= 1'b0;
         loss_cnt_q   <= '0;
      end else begin
         ready_q <= (state_q == StRun);
         unique case (state_q)
            StWaitLock: begin
               if (lk_s) begin
                  state_q      <= StStable;
                  stable_cnt_q <= StabW'(1);
               end
            end
            StStable: begin
               if (!lk_s) begin
                  state_q      <= StWaitLock;
                  stable_cnt_q <= '0;
               end else begin
                  stable_cnt_q <= stable_cnt_q + 1'b1;
                  if (stable_cnt_q == StabW'(LOCK_STABLE - 1)) begin
                     state_q <= StRun;
                  end
               end
            end
            StRun: begin
               if (!lk_s) begin
                  state_q      <= StWaitLock;
                  stable_cnt_q <= '0;
                  if (loss_cnt_q != '1) begin
                     loss_cnt_q <= loss_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q      <= StWaitLock;
               stable_cnt_q <= '0;
            end
         endcase
      end
   end

   // Increment registers; an out-of-range inc_sel matches no channel.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         inc_d[i] = inc_q[i];
         if (bus.inc_wr && (bus.inc_sel == 3'(i))) begin
            inc_d[i] = bus.inc_data;
         end
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            inc_q[i] <= INC_INIT[i*ACC_WIDTH +: ACC_WIDTH];
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            inc_q[i] <= inc_d[i];
         end
      end
   end

   // Channels are held cleared while not ready so every lock restarts them
   // phase-aligned.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_en_accum #(
         .ACC_WIDTH(ACC_WIDTH)
      ) u_accum (
         .sys_clk (sys_clk),
         .rst     (rst),
         .en_i    (ready_q & bus.ch_en[g]),
         .clear_i (~ready_q),
         .inc_i   (inc_q[g]),
         .ce_o    (ce_w[g])
      );
   end

   assign bus.ce            = ce_w;
   assign bus.ready         = ready_q;
   assign bus.lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// ----------------------------------------------------------------------------
// tb_clk_enable_gen
// Directed bench: stimulus pushes hand-computed per-cycle expectations into a
// scoreboard queue; a monitor pops and compares them on the falling edge (or
// just after an asynchronous reset assertion for entries tagged cycle -1).
// ----------------------------------------------------------------------------
module tb_clk_enable_gen;

   localparam int unsigned NumCh      = 4;
   localparam int unsigned AccW       = 8;
   localparam int unsigned CntW       = 8;
   localparam int unsigned LockStable = 16;
   // ch3 = 0, ch2 = 64, ch1 = 96, ch0 = 64
   localparam logic [NumCh*AccW-1:0] IncInit = {8'd0, 8'd64, 8'd96, 8'd64};

   logic sys_clk = 1'b0;
   logic rst     = 1'b1;
   int   cyc     = 0;

   clk_enable_gen_if #(
      .NUM_CH    (NumCh),
      .ACC_WIDTH (AccW),
      .CNT_W     (CntW)
   ) bus ();

   clk_enable_gen #(
      .NUM_CH      (NumCh),
      .ACC_WIDTH   (AccW),
      .INC_INIT    (IncInit),
      .LOCK_STABLE (LockStable),
      .CNT_W       (CntW)
   ) dut (
      .sys_clk (sys_clk),
      .rst     (rst),
      .bus     (bus)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [3:0] ce;
      logic [3:0] mask;
      logic       ready;
      logic [7:0] cnt;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_err    = 0;

   // ce patterns after a phase-aligned start (k = 1..8 cycles after ready).
   logic [3:0] pat_lock [8] = '{4'b0000, 4'b0000, 4'b0010, 4'b0101,
                                4'b0000, 4'b0010, 4'b0000, 4'b0111};
   // Increment writes: ch0 128 at T, back to 64 at T+6, ignored sel=7 at T+16.
   logic [3:0] pat_wr [32] = '{4'b0000, 4'b0000, 4'b0011, 4'b0100,
                               4'b0001, 4'b0010, 4'b0001, 4'b0110,
                               4'b0000, 4'b0001, 4'b0010, 4'b0100,
                               4'b0000, 4'b0011, 4'b0000, 4'b0110,
                               4'b0000, 4'b0001, 4'b0010, 4'b0100,
                               4'b0000, 4'b0011, 4'b0000, 4'b0110,
                               4'b0000, 4'b0001, 4'b0010, 4'b0100,
                               4'b0000, 4'b0011, 4'b0000, 4'b0110};
   // ch_en[2] low for edges U+2..U+11 with acc2 held at 64.
   logic [3:0] pat_en [18] = '{4'b0000, 4'b0001, 4'b0010, 4'b0000,
                               4'b0000, 4'b0011, 4'b0000, 4'b0010,
                               4'b0000, 4'b0001, 4'b0010, 4'b0000,
                               4'b0000, 4'b0111, 4'b0000, 4'b0010,
                               4'b0000, 4'b0101};

   function automatic void push(int c, logic [3:0] ce, logic [3:0] mask, logic rdy,
                                logic [7:0] cnt, string name);
      exp_t e;
      e.cyc   = c;
      e.ce    = ce;
      e.mask  = mask;
      e.ready = rdy;
      e.cnt   = cnt;
      e.name  = name;
      sb.push_back(e);
   endfunction

   function automatic void compare(exp_t e);
      n_checks++;
      if ((bus.ce & e.mask) !== (e.ce & e.mask)) begin
         n_err++;
         $display("FAIL %s@%0d ce: got %b want %b (mask %b)", e.name, e.cyc, bus.ce, e.ce,
                  e.mask);
      end
      n_checks++;
      if (bus.ready !== e.ready) begin
         n_err++;
         $display("FAIL %s@%0d ready: got %b want %b", e.name, e.cyc, bus.ready, e.ready);
      end
      n_checks++;
      if (bus.lock_loss_cnt !== e.cnt) begin
         n_err++;
         $display("FAIL %s@%0d lock_loss_cnt: got %0d want %0d", e.name, e.cyc,
                  bus.lock_loss_cnt, e.cnt);
      end
   endfunction

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge sys_clk or posedge rst);
         if (rst && sb.size() > 0 && sb[0].cyc < 0) begin
            #1;
            e = sb.pop_front();
            compare(e);
         end else begin
            while (sb.size() > 0 && sb[0].cyc >= 0 && sb[0].cyc < cyc) begin
               e = sb.pop_front();
               n_checks++;
               n_err++;
               $display("FAIL %s missed: got no sample want check at cycle %0d", e.name, e.cyc);
            end
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
               e = sb.pop_front();
               compare(e);
            end
         end
      end
   end

   task automatic goto(int c);
      while (cyc < c) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 2000) begin
         @(posedge sys_clk);
         #1;
         n++;
      end
      if (sb.size() > 0) begin
         n_checks++;
         n_err++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #50000;
      $display("FAIL timeout: got no finish want finish before 50000");
      $fatal(1, "timeout");
   end

   // Stimulus
   initial begin
      int r, t, u, v, c1;
      bus.pll_locked = 1'b0;
      bus.ch_en      = 4'h0;
      bus.inc_wr     = 1'b0;
      bus.inc_sel    = 3'd0;
      bus.inc_data   = 8'd0;
      rst            = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1;
      push(cyc + 1, 4'h0, 4'hf, 1'b0, 8'd0, "reset_state");
      drain();

      // Lock acquisition: ready 2 + 16 + 1 edges after the first locked edge.
      bus.ch_en      = 4'hf;
      rst            = 1'b0;
      bus.pll_locked = 1'b1;
      r = cyc + 19;
      for (int k = 1; k <= 18; k++) push(cyc + k, 4'h0, 4'hf, 1'b0, 8'd0, "lock_wait");
      push(r, 4'h0, 4'hf, 1'b1, 8'd0, "ready_rise");
      for (int k = 1; k <= 16; k++) push(r + k, pat_lock[(k-1)%8], 4'hf, 1'b1, 8'd0, "ch_pattern");
      for (int k = 17; k <= 272; k++) push(r + k, 4'h0, 4'b1000, 1'b1, 8'd0, "inc_zero");
      drain();

      // Align to a cycle where acc0/1/2 are all zero.
      do begin
         @(posedge sys_clk);
         #1;
      end while (((cyc - r) % 8) != 0);
      t = cyc;
      for (int j = 1; j <= 32; j++) push(t + j, pat_wr[j-1], 4'hf, 1'b1, 8'd0, "inc_write");
      bus.inc_wr   = 1'b1;
      bus.inc_sel  = 3'd0;
      bus.inc_data = 8'd128;
      goto(t + 1);
      bus.inc_wr   = 1'b0;
      goto(t + 6);
      bus.inc_wr   = 1'b1;
      bus.inc_data = 8'd64;
      goto(t + 7);
      bus.inc_wr   = 1'b0;
      goto(t + 16);
      bus.inc_wr   = 1'b1;
      bus.inc_sel  = 3'd7;
      bus.inc_data = 8'hff;
      goto(t + 17);
      bus.inc_wr   = 1'b0;
      bus.inc_sel  = 3'd0;

      // Channel 2 paused mid-phase, then resumed.
      u = t + 32;
      goto(u);
      for (int j = 1; j <= 18; j++) push(u + j, pat_en[j-1], 4'hf, 1'b1, 8'd0, "ch_pause");
      goto(u + 1);
      bus.ch_en = 4'b1011;
      goto(u + 11);
      bus.ch_en = 4'hf;

      // One-cycle lock drop in RUN, then a glitch while STABLE.
      v = u + 18;
      goto(v);
      push(v + 1, 4'b0010, 4'hf, 1'b1, 8'd0, "lock_drop");
      push(v + 2, 4'b0000, 4'hf, 1'b1, 8'd0, "lock_drop");
      push(v + 3, 4'b0000, 4'hf, 1'b1, 8'd1, "loss_count");
      push(v + 4, 4'b0111, 4'hf, 1'b0, 8'd1, "ready_fall");
      for (int k = 5; k <= 27; k++) push(v + k, 4'h0, 4'hf, 1'b0, 8'd1, "relock_wait");
      push(v + 28, 4'h0, 4'hf, 1'b1, 8'd1, "relock_ready");
      for (int k = 1; k <= 8; k++) push(v + 28 + k, pat_lock[k-1], 4'hf, 1'b1, 8'd1, "relock_pattern");
      bus.pll_locked = 1'b0;
      goto(v + 1);
      bus.pll_locked = 1'b1;
      goto(v + 8);
      bus.pll_locked = 1'b0;
      goto(v + 9);
      bus.pll_locked = 1'b1;

      // Change ch3, then reset between edges: outputs clear at once and
      // increments return to their reset values.
      goto(v + 36);
      bus.inc_wr   = 1'b1;
      bus.inc_sel  = 3'd3;
      bus.inc_data = 8'd128;
      goto(v + 37);
      bus.inc_wr   = 1'b0;
      #1;
      push(-1, 4'h0, 4'hf, 1'b0, 8'd0, "async_rst");
      rst = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1;
      drain();
      rst = 1'b0;
      c1  = cyc;
      for (int k = 1; k <= 18; k++) push(c1 + k, 4'h0, 4'hf, 1'b0, 8'd0, "post_rst_wait");
      push(c1 + 19, 4'h0, 4'hf, 1'b1, 8'd0, "post_rst_ready");
      for (int k = 1; k <= 8; k++) push(c1 + 19 + k, pat_lock[k-1], 4'hf, 1'b1, 8'd0, "post_rst_pattern");
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
